// File: rtl/da_bit_serializer.sv
// da_bit_serializer: input-side feeder for a 64-tap distributed-arithmetic FIR core.
//
// Keeps a 64-deep delay line of two's-complement samples (tap 0 newest, tap 63 oldest).
// Each sample accepted over the valid/ready handshake shifts the line once. The block then
// emits DATA_W registered bit-slices, MSB first, one per clock. The delay line stays frozen
// while a frame is being serialised.
//
// Ports:
//   clk3         system clock, rising edge
//   reset        asynchronous active-low reset
//   in_data      new sample (DATA_W bits, two's complement)
//   in_valid     in_data is valid
//   in_ready     block can accept a sample this cycle
//   flush        synchronous clear of the delay line (honoured only when idle)
//   x1_bit..x8_bit  bit-slice of taps 0..63; xN_bit[j] = tap 8*(N-1)+j
//   slice_valid  x*_bit carry a valid slice
//   first_slice  current slice is the MSB (sign) slice
//   last_slice   current slice is the LSB slice
module da_bit_serializer #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk3,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [7:0]        x1_bit,
    output logic [7:0]        x2_bit,
    output logic [7:0]        x3_bit,
    output logic [7:0]        x4_bit,
    output logic [7:0]        x5_bit,
    output logic [7:0]        x6_bit,
    output logic [7:0]        x7_bit,
    output logic [7:0]        x8_bit,
    output logic              slice_valid,
    output logic              first_slice,
    output logic              last_slice
);

    localparam int unsigned NumTaps = 64;
    localparam int unsigned IdxW    = $clog2(DATA_W);
    localparam logic [IdxW-1:0] MsbIdx = IdxW'(DATA_W - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSerial
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] taps_q [NumTaps];
    logic [DATA_W-1:0] taps_d [NumTaps];
    logic [NumTaps-1:0] slice_q, slice_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;

    // Flush has priority over the handshake, so it also masks ready.
    assign in_ready = reset & (state_q == StIdle) & ~flush;

    // Next-state: delay line, FSM and bit index (bit_idx_q = bit currently on the outputs).
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        taps_d    = taps_q;
        case (state_q)
            StIdle: begin
                if (flush) begin
                    for (int k = 0; k < NumTaps; k++) begin
                        taps_d[k] = '0;
                    end
                end else if (in_valid && in_ready) begin
                    taps_d[0] = in_data;
                    for (int k = 1; k < NumTaps; k++) begin
                        taps_d[k] = taps_q[k-1];
                    end
                    state_d   = StSerial;
                    bit_idx_d = MsbIdx;
                end
            end
            StSerial: begin
                if (bit_idx_q == '0) begin
                    state_d   = StIdle;
                    bit_idx_d = MsbIdx;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                bit_idx_d = MsbIdx;
            end
        endcase
    end

    // Slice registers are loaded from next-state taps/index so the MSB slice appears
    // the cycle right after the handshake.
    always_comb begin
        slice_d = '0;
        valid_d = (state_d == StSerial);
        first_d = valid_d && (bit_idx_d == MsbIdx);
        last_d  = valid_d && (bit_idx_d == '0);
        if (valid_d) begin
            for (int k = 0; k < NumTaps; k++) begin
                slice_d[k] = taps_d[k][bit_idx_d];
            end
        end
    end

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_idx_q <= MsbIdx;
            taps_q    <= '{default: '0};
            slice_q   <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            taps_q    <= taps_d;
            slice_q   <= slice_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    assign x1_bit      = slice_q[7:0];
    assign x2_bit      = slice_q[15:8];
    assign x3_bit      = slice_q[23:16];
    assign x4_bit      = slice_q[31:24];
    assign x5_bit      = slice_q[39:32];
    assign x6_bit      = slice_q[47:40];
    assign x7_bit      = slice_q[55:48];
    assign x8_bit      = slice_q[63:56];
    assign slice_valid = valid_q;
    assign first_slice = first_q;
    assign last_slice  = last_q;

endmodule

// File: tb/tb_da_bit_serializer.sv
// Self-checking bench for da_bit_serializer (DATA_W = 16).
// Reference model: an array of 64 sample values shifted on every accepted sample; the
// expected slice for bit b is bit b of each array entry.
module tb_da_bit_serializer;

    localparam int W = 16;

    logic         clk3 = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [7:0]   x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit;
    logic         slice_valid, first_slice, last_slice;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] line [64];

    da_bit_serializer #(.DATA_W(W)) dut (
        .clk3        (clk3),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .x1_bit      (x1_bit),
        .x2_bit      (x2_bit),
        .x3_bit      (x3_bit),
        .x4_bit      (x4_bit),
        .x5_bit      (x5_bit),
        .x6_bit      (x6_bit),
        .x7_bit      (x7_bit),
        .x8_bit      (x8_bit),
        .slice_valid (slice_valid),
        .first_slice (first_slice),
        .last_slice  (last_slice)
    );

    always #5 clk3 = ~clk3;

    function automatic logic [63:0] dut_slice();
        return {x8_bit, x7_bit, x6_bit, x5_bit, x4_bit, x3_bit, x2_bit, x1_bit};
    endfunction

    function automatic logic [63:0] model_slice(input int b);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) r[k] = line[k][b];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 64; k++) line[k] = '0;
    endtask

    task automatic model_push(input logic [W-1:0] d);
        for (int k = 63; k > 0; k--) line[k] = line[k-1];
        line[0] = d;
    endtask

    // Called at a negedge; returns at the negedge of cycle W+1 (idle again).
    task automatic push(input logic [W-1:0] d, output logic [63:0] first_s,
                        output logic [63:0] last_s);
        int n;
        first_s  = '0;
        last_s   = '0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk3);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("push_wait_ready", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk3);
        model_push(d);
        for (int t = 1; t <= W; t++) begin
            @(negedge clk3);
            in_valid = 1'b0;
            check("slice_data", dut_slice(), model_slice(W - t));
            check("slice_flags", {60'd0, slice_valid, first_slice, last_slice, in_ready},
                  {60'd0, 1'b1, t == 1, t == W, 1'b0});
            if (t == 1) first_s = dut_slice();
            if (t == W) last_s = dut_slice();
        end
        @(negedge clk3);
        check("frame_end", {62'd0, slice_valid, in_ready}, 64'd1);
    endtask

    // Flush together with in_valid while idle: must not accept.
    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        #1;
        check("flush_ready_low", {63'd0, in_ready}, 64'd0);
        @(negedge clk3);
        flush    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        check("flush_no_accept", {62'd0, slice_valid, in_ready}, 64'd1);
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [7:0]   exp_msb_x1;
        logic [7:0]   exp_lsb_x1;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        logic [63:0] fs, ls;
        int          acc [$];
        int          sv_cnt;
        logic [W-1:0] d;

        vecs[0] = '{16'h8001, 8'h01, 8'h01};
        vecs[1] = '{16'h0001, 8'h00, 8'h01};
        vecs[2] = '{16'h8000, 8'h01, 8'h00};
        vecs[3] = '{16'h7FFE, 8'h00, 8'h00};
        vecs[4] = '{16'hFFFF, 8'h01, 8'h01};

        reset    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        flush    = 1'b0;
        model_clear();

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk3);
            check("rst_ready", {63'd0, in_ready}, 64'd0);
            check("rst_outputs", {dut_slice()}, 64'd0);
        end
        reset = 1'b1;
        @(negedge clk3);
        check("idle_ready", {63'd0, in_ready}, 64'd1);
        check("idle_flags", {61'd0, slice_valid, first_slice, last_slice}, 64'd0);
        check("idle_outputs", dut_slice(), 64'd0);

        // Single samples into an empty line
        foreach (vecs[i]) begin
            do_flush();
            @(negedge clk3);
            push(vecs[i].din, fs, ls);
            check("tbl_msb_x1", {56'd0, fs[7:0]}, {56'd0, vecs[i].exp_msb_x1});
            check("tbl_lsb_x1", {56'd0, ls[7:0]}, {56'd0, vecs[i].exp_lsb_x1});
            check("tbl_other_taps", {fs[63:8] | ls[63:8]}, 64'd0);
        end

        // Tap ordering: FFFF then 8 zeros -> FFFF sits in tap 8
        do_flush();
        @(negedge clk3);
        push(16'hFFFF, fs, ls);
        for (int i = 0; i < 8; i++) push(16'h0000, fs, ls);
        check("order_first", fs, 64'h0000_0000_0000_0100);
        check("order_last", ls, 64'h0000_0000_0000_0100);

        // Wrap-around
        do_flush();
        @(negedge clk3);
        push(16'h0001, fs, ls);
        for (int i = 0; i < 63; i++) push(16'h0000, fs, ls);
        check("wrap_frame64_x8", {56'd0, ls[63:56]}, 64'h80);
        push(16'h0000, fs, ls);
        check("wrap_frame65", fs | ls, 64'd0);

        // Back-to-back with in_valid held high
        d        = 16'h0100;
        in_data  = d;
        in_valid = 1'b1;
        sv_cnt   = 0;
        for (int cyc = 0; cyc < 4 * (W + 1); cyc++) begin
            #1;
            if (slice_valid) begin
                sv_cnt++;
                check("b2b_ready_low", {63'd0, in_ready}, 64'd0);
            end
            if (in_ready) begin
                acc.push_back(cyc);
                model_push(d);
                @(negedge clk3);
                d++;
                in_data = d;
            end else begin
                @(negedge clk3);
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", 64'(acc.size()), 64'd4);
        for (int i = 1; i < acc.size(); i++)
            check("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'(W + 1));
        check("b2b_slice_count", 64'(sv_cnt), 64'(4 * W));
        @(negedge clk3);

        // Randomised traffic with idle gaps
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk3);
            push(W'($urandom), fs, ls);
        end

        // Reset in the middle of a frame
        in_data  = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk3);
        model_push(16'h1234);
        @(negedge clk3);
        in_valid = 1'b0;
        repeat (4) @(negedge clk3);
        check("mid_slice5_valid", {63'd0, slice_valid}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {60'd0, slice_valid, first_slice, last_slice, in_ready}, 64'd0);
        check("mid_rst_outputs", dut_slice(), 64'd0);
        @(negedge clk3);
        reset = 1'b1;
        model_clear();
        #1;
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk3);
        push(16'h0003, fs, ls);
        check("post_rst_first", fs, 64'd0);
        check("post_rst_last", ls, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/da_bit_serializer.md
Name: da_bit_serializer

Overview:
- Input-side feeder for the 64-tap distributed-arithmetic FIR core.
- Accepts parallel two's-complement samples through a valid/ready handshake and keeps a 64-deep sample delay line.
- For each accepted sample it emits DATA_W bit-slices, MSB first, on eight 8-bit buses, one slice per clock.
- Also marks the first (sign) and last slice of each frame for the downstream shift-accumulator.

Parameters:
- DATA_W, 16, sample width in bits; legal range 2..32.

Ports:
- clk3  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  new sample, two's complement.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- flush  input  1  synchronous request to clear the delay line to zero.
- x1_bit  output  8  bit-slice of taps 0..7; bit j = tap j.
- x2_bit  output  8  bit-slice of taps 8..15; bit j = tap 8+j.
- x3_bit..x8_bit  output  8 each  taps 16..23 through 56..63, same mapping.
- slice_valid  output  1  x*_bit hold a valid slice.
- first_slice  output  1  current slice is the MSB (sign) slice.
- last_slice  output  1  current slice is the LSB slice; frame ends.

Behaviour:
- Reset (reset=0, asynchronous):
  - All 64 taps cleared to 0; state forced to IDLE; bit index forced to DATA_W-1.
  - x1_bit..x8_bit, slice_valid, first_slice and last_slice are 0 while reset is low and after it is released.
  - in_ready is 0 while reset is low.
- Tap 0 is the newest sample; tap 63 is the oldest.
- State IDLE:
  - in_ready = !flush (combinational); all slice outputs are 0.
  - flush=1: all taps cleared to 0 on the next edge; any in_valid that cycle is not accepted (flush has priority); stay in IDLE.
  - in_valid=1 and in_ready=1 (the handshake, cycle 0): tap k <= tap k-1 for k=63..1, tap 0 <= in_data, old tap 63 is discarded; go to SERIAL with bit index = DATA_W-1.
- State SERIAL:
  - in_ready = 0; flush is ignored (not latched).
  - Each cycle, output registers present bit[bit index] of every tap, with slice_valid=1.
  - first_slice=1 when bit index = DATA_W-1; last_slice=1 when bit index = 0.
  - Bit index decrements each cycle; after the bit-0 slice the state returns to IDLE.
- Latency and throughput:
  - All slice outputs are registered.
  - For a handshake in cycle 0, the MSB slice is visible in cycle 1 and the LSB slice in cycle DATA_W.
  - in_ready returns high in cycle DATA_W+1.
  - Maximum throughput is one sample per DATA_W+1 cycles.
- The delay line is frozen during SERIAL, so every slice of a frame uses the same 64 taps.
- Upstream must hold in_data and in_valid until in_ready is seen; no data is dropped or duplicated.
- Reset asserted mid-SERIAL: the frame is aborted immediately, taps cleared, and slice_valid drops asynchronously.
- Delay line wrap-around: after more than 64 accepted samples, the oldest sample falls off tap 63 silently.
- DATA_W=2: frames are two slices long; first_slice and last_slice are never high in the same cycle.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset=0 for 3 cycles, then release with in_valid=0.
  - Required: all x*_bit=0, slice_valid=0, in_ready=1.
- Single sample (DATA_W=16):
  - Stimulus: empty line, push 16'h8001.
  - Required: cycles 1..16 have x1_bit=8'h01 in cycle 1 (first_slice=1), 8'h00 in cycles 2..15, and 8'h01 in cycle 16 (last_slice=1); x2_bit..x8_bit=0 throughout; in_ready=1 in cycle 17.
- Tap ordering:
  - Stimulus: push 16'hFFFF, then 8 zeros (9 samples total).
  - Required: in the 9th frame every slice has x1_bit=0 and x2_bit=8'h01; x2_bit bit 0 = tap 8.
- Wrap-around:
  - Stimulus: push 1, then 64 zeros.
  - Required: frame 64 shows x8_bit=8'h80 on its LSB slice; frame 65 shows all slices 0.
- Back-to-back handshake:
  - Stimulus: hold in_valid=1 with incrementing data.
  - Required: a sample is accepted every 17 cycles; in_ready is 0 in all SERIAL cycles; exactly 16 slice_valid cycles per sample.
- Flush and reset mid-frame:
  - Stimulus A: flush=1 together with in_valid=1 in IDLE.
    - Required: no acceptance; all taps 0 on the next frame.
  - Stimulus B: reset=0 asserted at slice 5.
    - Required: slice_valid=0 immediately; after release, the next frame for sample 16'h0003 shows only x1_bit bit 0 set in slices 15 and 16.
